// File: rtl/jtframe_bank_share.sv
// Round-robin sharing of one SDRAM bank port among NREQ requesters.
// One transaction in flight at a time: IDLE (arbitrate) -> CMD (wait ack) -> WAIT (wait rdy).
module jtframe_bank_share #(
  parameter int AW   = 22,
  parameter int NREQ = 3
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*16-1:0]   req_din,
  input  logic [NREQ*2-1:0]    req_dsn,
  output logic [NREQ-1:0]      req_ok,
  output logic [15:0]          req_dout,
  output logic                 busy,
  output logic [2:0]           grant,
  output logic [AW-1:0]        ba_addr,
  output logic                 ba_rd,
  output logic                 ba_wr,
  output logic [15:0]          ba_din,
  output logic [1:0]           ba_dsn,
  input  logic                 ba_ack,
  input  logic                 ba_rdy,
  input  logic [15:0]          sdram_dout
);

  localparam int MAXREQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WAIT
  } state_t;

  state_t          state_reg,   state_next;
  logic [2:0]      rr_reg,      rr_next;
  logic [2:0]      grant_reg,   grant_next;
  logic            busy_reg,    busy_next;
  logic            we_reg,      we_next;
  logic [AW-1:0]   addr_reg,    addr_next;
  logic [15:0]     din_reg,     din_next;
  logic [1:0]      dsn_reg,     dsn_next;
  logic            ba_rd_reg,   ba_rd_next;
  logic            ba_wr_reg,   ba_wr_next;
  logic [NREQ-1:0] ok_reg,      ok_next;
  logic [NREQ-1:0] holdoff_reg, holdoff_next;
  logic [15:0]     dout_reg,    dout_next;

  // Requester buses padded to 8 entries so a 3-bit grant index is always in range
  logic [AW-1:0]     addr_arr [MAXREQ];
  logic [15:0]       din_arr  [MAXREQ];
  logic [1:0]        dsn_arr  [MAXREQ];
  logic [MAXREQ-1:0] rd_ext;
  logic [MAXREQ-1:0] wr_ext;
  logic [MAXREQ-1:0] holdoff_ext;
  logic [MAXREQ-1:0] pend_ext;

  genvar gi;
  generate
    for (gi = 0; gi < MAXREQ; gi++) begin : g_unpack
      if (gi < NREQ) begin : g_used
        assign addr_arr[gi]    = req_addr[gi*AW +: AW];
        assign din_arr[gi]     = req_din[gi*16 +: 16];
        assign dsn_arr[gi]     = req_dsn[gi*2 +: 2];
        assign rd_ext[gi]      = req_rd[gi];
        assign wr_ext[gi]      = req_wr[gi];
        assign holdoff_ext[gi] = holdoff_reg[gi];
      end else begin : g_unused
        assign addr_arr[gi]    = '0;
        assign din_arr[gi]     = '0;
        assign dsn_arr[gi]     = '0;
        assign rd_ext[gi]      = 1'b0;
        assign wr_ext[gi]      = 1'b0;
        assign holdoff_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign pend_ext = (rd_ext | wr_ext) & ~holdoff_ext;

  // First pending requester at or after the round-robin pointer, wrapping at NREQ
  logic [2:0] pick;
  logic       pick_valid;
  logic [3:0] idx;

  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_reg} + 4'(k);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      if (!pick_valid && pend_ext[idx[2:0]]) begin
        pick       = idx[2:0];
        pick_valid = 1'b1;
      end
    end
  end

  logic [NREQ-1:0] grant_onehot;

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_onehot[i] = (grant_reg == 3'(i));
    end
  end

  // A bank that acks and completes in the same cycle skips WAIT entirely
  logic finish;
  assign finish = ((state_reg == ST_CMD) && ba_ack && ba_rdy) ||
                  ((state_reg == ST_WAIT) && ba_rdy);

  always_comb begin
    state_next   = state_reg;
    rr_next      = rr_reg;
    grant_next   = grant_reg;
    busy_next    = busy_reg;
    we_next      = we_reg;
    addr_next    = addr_reg;
    din_next     = din_reg;
    dsn_next     = dsn_reg;
    ba_rd_next   = ba_rd_reg;
    ba_wr_next   = ba_wr_reg;
    ok_next      = '0;
    holdoff_next = '0;
    dout_next    = dout_reg;

    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_next = pick;
          busy_next  = 1'b1;
          we_next    = wr_ext[pick];
          addr_next  = addr_arr[pick];
          din_next   = din_arr[pick];
          dsn_next   = wr_ext[pick] ? dsn_arr[pick] : 2'b00;
          ba_rd_next = ~wr_ext[pick];
          ba_wr_next = wr_ext[pick];
          state_next = ST_CMD;
        end
      end
      ST_CMD: begin
        if (ba_ack) begin
          ba_rd_next = 1'b0;
          ba_wr_next = 1'b0;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
      end
      default: state_next = ST_IDLE;
    endcase

    if (finish) begin
      busy_next    = 1'b0;
      ok_next      = grant_onehot;
      holdoff_next = grant_onehot;
      rr_next      = (grant_reg == 3'(NREQ-1)) ? 3'd0 : grant_reg + 3'd1;
      state_next   = ST_IDLE;
      if (!we_reg) dout_next = sdram_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      rr_reg      <= '0;
      grant_reg   <= '0;
      busy_reg    <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      din_reg     <= '0;
      dsn_reg     <= '0;
      ba_rd_reg   <= 1'b0;
      ba_wr_reg   <= 1'b0;
      ok_reg      <= '0;
      holdoff_reg <= '0;
      dout_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      rr_reg      <= rr_next;
      grant_reg   <= grant_next;
      busy_reg    <= busy_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      din_reg     <= din_next;
      dsn_reg     <= dsn_next;
      ba_rd_reg   <= ba_rd_next;
      ba_wr_reg   <= ba_wr_next;
      ok_reg      <= ok_next;
      holdoff_reg <= holdoff_next;
      dout_reg    <= dout_next;
    end
  end

  assign req_ok   = ok_reg;
  assign req_dout = dout_reg;
  assign busy     = busy_reg;
  assign grant    = grant_reg;
  assign ba_addr  = addr_reg;
  assign ba_rd    = ba_rd_reg;
  assign ba_wr    = ba_wr_reg;
  assign ba_din   = din_reg;
  assign ba_dsn   = dsn_reg;

endmodule
